ps_pcstk_ctrl: RTL

- Program-sequencer PC-stack controller.
- Owns the hardware PC stack: storage array, stack pointer, top-of-stack read, full/empty status, sticky overflow/underflow flags.
- Sequences push/pop requests decoded by the universal-register decoder (push-stack, pop-stack) and the universal-register write/read of PCSTK.
- Sits between the ureg decode stage and the sequencer's PC mux and status logic.

---
 rtl/ps_pcstk_ctrl_if.sv | 28 ++
 rtl/ps_pcstk_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/ps_pcstk_ctrl_if.sv
// rtl/ps_pcstk_ctrl_if.sv - request/status bundle between ureg decode/sequencer and the PC-stack controller
interface ps_pcstk_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int PTR_W = 5
);
    logic             ps_push;
    logic             ps_pop;
    logic [WIDTH-1:0] ps_push_data;
    logic             ps_top_wrt_en;
    logic [WIDTH-1:0] ps_top_wrt_data;
    logic             ps_flg_clr;
    logic [WIDTH-1:0] ps_pcstk_top;
    logic [PTR_W-1:0] ps_pcstkp;
    logic             ps_stck_empty;
    logic             ps_stck_full;
    logic             ps_stck_ovf;
    logic             ps_stck_unf;

    modport master (
        output ps_push, ps_pop, ps_push_data, ps_top_wrt_en, ps_top_wrt_data, ps_flg_clr,
        input  ps_pcstk_top, ps_pcstkp, ps_stck_empty, ps_stck_full, ps_stck_ovf, ps_stck_unf
    );

    modport slave (
        input  ps_push, ps_pop, ps_push_data, ps_top_wrt_en, ps_top_wrt_data, ps_flg_clr,
        output ps_pcstk_top, ps_pcstkp, ps_stck_empty, ps_stck_full, ps_stck_ovf, ps_stck_unf
    );
endinterface

// File: rtl/ps_pcstk_ctrl.sv
// rtl/ps_pcstk_ctrl.sv - hardware PC stack: storage, pointer, top read, full/empty and sticky error flags
module ps_pcstk_ctrl #(
    parameter int DEPTH = 30,
    parameter int WIDTH = 16,
    parameter int PTR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    ps_pcstk_ctrl_if.slave    bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] count_nxt;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             set_ovf;
    logic             set_unf;
    logic             ovf;
    logic             unf;
    logic             empty;
    logic             full;

    assign empty   = (count == '0);
    assign full    = (count == PTR_W'(DEPTH));
    assign top_idx = count - PTR_W'(1);

    always_comb begin
        count_nxt = count;
        wr_en     = 1'b0;
        wr_addr   = top_idx;
        wr_data   = bus.ps_push_data;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case ({bus.ps_push, bus.ps_pop})
            2'b10: begin
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = count;
                    count_nxt = count + PTR_W'(1);
                end
            end
            2'b01: begin
                if (empty) set_unf = 1'b1;
                else       count_nxt = top_idx;
            end
            2'b11: begin
                // push+pop replaces the top; on an empty stack it degenerates to a plain push
                wr_en = 1'b1;
                if (empty) begin
                    wr_addr   = '0;
                    count_nxt = PTR_W'(1);
                end
            end
            default: begin
                if (bus.ps_top_wrt_en) begin
                    if (empty) begin
                        set_unf = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_data = bus.ps_top_wrt_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= set_ovf | (ovf & ~bus.ps_flg_clr);
            unf   <= set_unf | (unf & ~bus.ps_flg_clr);
        end
    end

    // storage is not reset, but reset still blocks any write requested in the same cycle
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_addr] <= wr_data;
    end

    assign bus.ps_pcstk_top  = empty ? '0 : mem[top_idx];
    assign bus.ps_pcstkp     = count;
    assign bus.ps_stck_empty = empty;
    assign bus.ps_stck_full  = full;
    assign bus.ps_stck_ovf   = ovf;
    assign bus.ps_stck_unf   = unf;
endmodule
